mask_apply: RTL and testbench

MASK_APPLY -- requirements
Module: mask_apply

---
 rtl/mask_apply.sv | 115 +++++++++++
 tb/tb_mask_apply.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mask_apply.sv
// Mask stage: pairs each edge pixel from the input FIFO with the mask BRAM
// value at the same raster position and passes or zeroes it on a gray threshold.
module mask_apply #(
  parameter int         WIDTH          = 720,
  parameter int         HEIGHT         = 540,
  parameter int         IMAGE_SIZE     = WIDTH * HEIGHT,
  parameter logic [7:0] MASK_THRESHOLD = 8'd128
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          mask_ready,
  output logic                          in_rd_en,
  input  logic                          in_empty,
  input  logic [7:0]                    in_dout,
  output logic [$clog2(IMAGE_SIZE)-1:0] mask_rd_addr,
  input  logic [7:0]                    mask_rd_data,
  output logic                          out_wr_en,
  input  logic                          out_full,
  output logic [7:0]                    out_din,
  output logic                          done
);

  localparam int unsigned ADDR_W = $clog2(IMAGE_SIZE);
  localparam int unsigned X_W    = $clog2(WIDTH);
  localparam int unsigned Y_W    = $clog2(HEIGHT);

  typedef enum logic [1:0] {IDLE, FETCH, WAIT, OUTPUT} state_t;

  state_t           state_q, state_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [7:0]       edge_reg_q, edge_reg_d;
  logic [7:0]       mask_reg_q, mask_reg_d;
  logic             pass;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      edge_reg_q <= 8'h00;
      mask_reg_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      edge_reg_q <= edge_reg_d;
      mask_reg_q <= mask_reg_d;
    end
  end

  // BRAM address tracks the raster counters so the read issued in FETCH lands in WAIT.
  assign mask_rd_addr = ADDR_W'(y_q) * ADDR_W'(WIDTH) + ADDR_W'(x_q);
  assign pass         = (mask_reg_q >= MASK_THRESHOLD);

  // Next-state and strobe logic; strobes are combinational so pop/push land in the decision cycle.
  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    edge_reg_d = edge_reg_q;
    mask_reg_d = mask_reg_q;
    in_rd_en   = 1'b0;
    out_wr_en  = 1'b0;
    out_din    = 8'h00;
    done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (mask_ready && !in_empty) begin
          state_d = FETCH;
          x_d     = '0;
          y_d     = '0;
        end
      end
      FETCH: begin
        if (!in_empty) begin
          in_rd_en   = 1'b1;
          edge_reg_d = in_dout;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        mask_reg_d = mask_rd_data;
        state_d    = OUTPUT;
      end
      OUTPUT: begin
        if (!out_full) begin
          out_wr_en = 1'b1;
          out_din   = pass ? edge_reg_q : 8'h00;
          if (x_q != X_W'(WIDTH - 1)) begin
            x_d     = x_q + X_W'(1);
            state_d = FETCH;
          end else if (y_q != Y_W'(HEIGHT - 1)) begin
            x_d     = '0;
            y_d     = y_q + Y_W'(1);
            state_d = FETCH;
          end else begin
            x_d     = '0;
            y_d     = '0;
            done    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        x_d     = '0;
        y_d     = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_mask_apply.sv
// Self-checking bench for mask_apply on a 4x2 frame with FIFO and BRAM models.
module tb_mask_apply;

  localparam int W = 4;
  localparam int H = 2;
  localparam int N = W * H;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mask_ready = 1'b0;
  logic       in_rd_en;
  logic       in_empty;
  logic [7:0] in_dout;
  logic [2:0] mask_rd_addr;
  logic [7:0] mask_rd_data;
  logic       out_wr_en;
  logic       out_full = 1'b0;
  logic [7:0] out_din;
  logic       done;

  int errors = 0;
  int checks = 0;

  mask_apply #(.WIDTH(W), .HEIGHT(H), .MASK_THRESHOLD(8'd128)) dut (
    .clock(clock), .reset(reset), .mask_ready(mask_ready),
    .in_rd_en(in_rd_en), .in_empty(in_empty), .in_dout(in_dout),
    .mask_rd_addr(mask_rd_addr), .mask_rd_data(mask_rd_data),
    .out_wr_en(out_wr_en), .out_full(out_full), .out_din(out_din), .done(done)
  );

  always #5 clock = ~clock;

  // First-word fall-through input FIFO model
  logic [7:0] fifo_mem [0:255];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign in_empty = (rd_ptr == wr_ptr);
  assign in_dout  = in_empty ? 8'h00 : fifo_mem[rd_ptr % 256];
  always @(posedge clock) if (in_rd_en && !in_empty) rd_ptr <= rd_ptr + 1;

  // Mask BRAM model with one-cycle read latency
  logic [7:0] mask_mem [0:N-1];
  always @(posedge clock) mask_rd_data <= mask_mem[mask_rd_addr];

  // Frame stimulus reference
  logic [7:0] frame_data [0:N-1];

  // Activity logs sampled mid-cycle
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [7:0] push_q[$];
  logic [2:0] push_addr_q[$];
  bit         push_done_q[$];
  int         push_cyc_q[$];
  logic [2:0] pop_addr_q[$];
  int         pop_cyc_q[$];
  int done_cnt = 0;
  int din_bad = 0;
  int strobe_in_reset = 0;

  always @(negedge clock) begin
    if (in_rd_en) begin
      pop_addr_q.push_back(mask_rd_addr);
      pop_cyc_q.push_back(cyc);
    end
    if (out_wr_en) begin
      push_q.push_back(out_din);
      push_addr_q.push_back(mask_rd_addr);
      push_done_q.push_back(done);
      push_cyc_q.push_back(cyc);
    end
    if (done) done_cnt++;
    if (!out_wr_en && out_din !== 8'h00) din_bad++;
    if (reset && (in_rd_en || out_wr_en || done || out_din !== 8'h00)) strobe_in_reset++;
  end

  function automatic logic [7:0] expect_px(input logic [7:0] m, input logic [7:0] d);
    return (m >= 8'd128) ? d : 8'h00;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_logs();
    push_q.delete(); push_addr_q.delete(); push_done_q.delete(); push_cyc_q.delete();
    pop_addr_q.delete(); pop_cyc_q.delete();
    done_cnt = 0; din_bad = 0; strobe_in_reset = 0;
  endtask

  task automatic push_word(input logic [7:0] v);
    fifo_mem[wr_ptr % 256] = v;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic load_frame();
    for (int k = 0; k < N; k++) push_word(frame_data[k]);
  endtask

  task automatic randomize_frame();
    for (int k = 0; k < N; k++) begin
      mask_mem[k]   = 8'($urandom_range(0, 255));
      frame_data[k] = 8'($urandom_range(0, 255));
    end
  endtask

  task automatic run_until_done(input int budget, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < budget; i++) begin
      tick();
      if (done_cnt > 0) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #1;
    checks++; if (in_rd_en !== 1'b0) begin errors++; $display("FAIL rst_in_rd_en: got %b want 0", in_rd_en); end
    checks++; if (out_wr_en !== 1'b0) begin errors++; $display("FAIL rst_out_wr_en: got %b want 0", out_wr_en); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", done); end
    checks++; if (out_din !== 8'h00) begin errors++; $display("FAIL rst_out_din: got %h want 00", out_din); end
    checks++; if (mask_rd_addr !== 3'd0) begin errors++; $display("FAIL rst_addr: got %0d want 0", mask_rd_addr); end
    repeat (3) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_pass_through();
    bit to;
    clear_logs();
    for (int k = 0; k < N; k++) begin
      mask_mem[k]   = 8'hFF;
      frame_data[k] = 8'((k + 1) * 10);
    end
    load_frame();
    push_word(8'd90);
    push_word(8'd100);
    mask_ready = 1'b1;
    run_until_done(100, to);
    mask_ready = 1'b0;
    repeat (4) tick();
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL pt_timeout: got timeout want done"); end
    checks++; if (push_q.size() != N) begin errors++; $display("FAIL pt_push_count: got %0d want %0d", push_q.size(), N); end
    checks++; if (pop_addr_q.size() != N) begin errors++; $display("FAIL pt_pop_count: got %0d want %0d", pop_addr_q.size(), N); end
    for (int k = 0; k < N && k < push_q.size(); k++) begin
      checks++; if (push_q[k] !== frame_data[k]) begin errors++; $display("FAIL pt_data[%0d]: got %0d want %0d", k, push_q[k], frame_data[k]); end
      checks++; if (push_done_q[k] !== (k == N - 1)) begin errors++; $display("FAIL pt_done_at[%0d]: got %b want %b", k, push_done_q[k], k == N - 1); end
      if (k < pop_cyc_q.size()) begin
        checks++; if (push_cyc_q[k] - pop_cyc_q[k] != 2) begin errors++; $display("FAIL pt_latency[%0d]: got %0d want 2", k, push_cyc_q[k] - pop_cyc_q[k]); end
      end
      if (k > 0 && k < pop_cyc_q.size()) begin
        checks++; if (pop_cyc_q[k] - pop_cyc_q[k-1] != 3) begin errors++; $display("FAIL pt_rate[%0d]: got %0d want 3", k, pop_cyc_q[k] - pop_cyc_q[k-1]); end
      end
    end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL pt_done_count: got %0d want 1", done_cnt); end
    checks++; if (wr_ptr - rd_ptr != 2) begin errors++; $display("FAIL pt_leftover: got %0d want 2", wr_ptr - rd_ptr); end
    checks++; if (din_bad != 0) begin errors++; $display("FAIL pt_idle_din: got %0d want 0", din_bad); end
    wr_ptr = rd_ptr;
  endtask

  task automatic test_threshold();
    bit to;
    clear_logs();
    for (int k = 0; k < N; k++) begin
      mask_mem[k]   = (k % 2 == 0) ? 8'h80 : 8'h7F;
      frame_data[k] = 8'hAA;
    end
    load_frame();
    mask_ready = 1'b1;
    run_until_done(100, to);
    mask_ready = 1'b0;
    tick();
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL th_timeout: got timeout want done"); end
    checks++; if (push_q.size() != N) begin errors++; $display("FAIL th_push_count: got %0d want %0d", push_q.size(), N); end
    for (int k = 0; k < N && k < push_q.size(); k++) begin
      checks++; if (push_q[k] !== ((k % 2 == 0) ? 8'hAA : 8'h00)) begin errors++; $display("FAIL th_data[%0d]: got %h want %h", k, push_q[k], (k % 2 == 0) ? 8'hAA : 8'h00); end
    end
  endtask

  task automatic test_mask_ready();
    bit to;
    int raise_cyc;
    clear_logs();
    randomize_frame();
    load_frame();
    repeat (20) tick();
    checks++; if (pop_addr_q.size() != 0) begin errors++; $display("FAIL mr_no_pop: got %0d want 0", pop_addr_q.size()); end
    mask_ready = 1'b1;
    raise_cyc = cyc;
    for (int i = 0; i < 5 && pop_cyc_q.size() == 0; i++) tick();
    checks++; if (pop_cyc_q.size() == 0 || pop_cyc_q[0] - raise_cyc > 2) begin errors++; $display("FAIL mr_first_pop: got pops=%0d want first pop within 2 cycles", pop_cyc_q.size()); end
    for (int i = 0; i < 30 && push_q.size() < 3; i++) tick();
    mask_ready = 1'b0;
    run_until_done(100, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL mr_timeout: got timeout want done"); end
    checks++; if (push_q.size() != N) begin errors++; $display("FAIL mr_push_count: got %0d want %0d", push_q.size(), N); end
    for (int k = 0; k < N && k < push_q.size(); k++) begin
      checks++; if (push_q[k] !== expect_px(mask_mem[k], frame_data[k])) begin errors++; $display("FAIL mr_data[%0d]: got %h want %h", k, push_q[k], expect_px(mask_mem[k], frame_data[k])); end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    clear_logs();
    for (int k = 0; k < N; k++) begin
      mask_mem[k]   = 8'hFF;
      frame_data[k] = 8'(3 * k + 1);
    end
    load_frame();
    mask_ready = 1'b1;
    for (int i = 0; i < 40 && pop_addr_q.size() < 3; i++) tick();
    checks++; if (pop_addr_q.size() != 3) begin errors++; $display("FAIL bp_reach: got %0d pops want 3", pop_addr_q.size()); end
    tick();
    out_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++; if (out_wr_en !== 1'b0) begin errors++; $display("FAIL bp_wr_en[%0d]: got %b want 0", i, out_wr_en); end
      checks++; if (out_din !== 8'h00) begin errors++; $display("FAIL bp_din[%0d]: got %h want 00", i, out_din); end
      checks++; if (mask_rd_addr !== 3'd2) begin errors++; $display("FAIL bp_addr[%0d]: got %0d want 2", i, mask_rd_addr); end
      tick();
    end
    out_full = 1'b0;
    run_until_done(100, to);
    mask_ready = 1'b0;
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout: got timeout want done"); end
    checks++; if (push_q.size() != N) begin errors++; $display("FAIL bp_push_count: got %0d want %0d", push_q.size(), N); end
    for (int k = 0; k < N && k < push_q.size(); k++) begin
      checks++; if (push_q[k] !== frame_data[k]) begin errors++; $display("FAIL bp_data[%0d]: got %0d want %0d", k, push_q[k], frame_data[k]); end
    end
  endtask

  task automatic test_empty_gaps();
    bit to;
    clear_logs();
    randomize_frame();
    mask_ready = 1'b1;
    for (int k = 0; k < N; k++) begin
      repeat ($urandom_range(0, 4)) tick();
      push_word(frame_data[k]);
      for (int i = 0; i < 20 && push_q.size() < k + 1; i++) tick();
    end
    run_until_done(20, to);
    mask_ready = 1'b0;
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL eg_timeout: got timeout want done"); end
    checks++; if (pop_addr_q.size() != N) begin errors++; $display("FAIL eg_pop_count: got %0d want %0d", pop_addr_q.size(), N); end
    checks++; if (push_q.size() != N) begin errors++; $display("FAIL eg_push_count: got %0d want %0d", push_q.size(), N); end
    for (int k = 0; k < N && k < pop_addr_q.size() && k < push_q.size(); k++) begin
      checks++; if (pop_addr_q[k] !== 3'(k)) begin errors++; $display("FAIL eg_pop_addr[%0d]: got %0d want %0d", k, pop_addr_q[k], k); end
      checks++; if (push_addr_q[k] !== 3'(k)) begin errors++; $display("FAIL eg_push_addr[%0d]: got %0d want %0d", k, push_addr_q[k], k); end
      checks++; if (push_q[k] !== expect_px(mask_mem[k], frame_data[k])) begin errors++; $display("FAIL eg_data[%0d]: got %h want %h", k, push_q[k], expect_px(mask_mem[k], frame_data[k])); end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int pops_at, pushes_at;
    clear_logs();
    randomize_frame();
    load_frame();
    mask_ready = 1'b1;
    for (int i = 0; i < 60 && push_q.size() < 5; i++) tick();
    checks++; if (push_q.size() != 5) begin errors++; $display("FAIL rm_reach: got %0d pushes want 5", push_q.size()); end
    reset = 1'b1;
    mask_ready = 1'b0;
    #1;
    checks++; if (in_rd_en !== 1'b0) begin errors++; $display("FAIL rm_async_rd_en: got %b want 0", in_rd_en); end
    checks++; if (mask_rd_addr !== 3'd0) begin errors++; $display("FAIL rm_async_addr: got %0d want 0", mask_rd_addr); end
    checks++; if (out_wr_en !== 1'b0 || done !== 1'b0 || out_din !== 8'h00) begin errors++; $display("FAIL rm_async_out: got wr=%b done=%b din=%h want 0", out_wr_en, done, out_din); end
    pops_at = pop_addr_q.size();
    pushes_at = push_q.size();
    repeat (3) tick();
    checks++; if (strobe_in_reset != 0) begin errors++; $display("FAIL rm_strobes: got %0d want 0", strobe_in_reset); end
    checks++; if (pop_addr_q.size() != pops_at || push_q.size() != pushes_at) begin errors++; $display("FAIL rm_activity: got pops=%0d pushes=%0d want %0d %0d", pop_addr_q.size(), push_q.size(), pops_at, pushes_at); end
    reset = 1'b0;
    wr_ptr = rd_ptr;
    tick();
    clear_logs();
    randomize_frame();
    load_frame();
    mask_ready = 1'b1;
    run_until_done(100, to);
    mask_ready = 1'b0;
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL rm_timeout: got timeout want done"); end
    checks++; if (push_q.size() != N) begin errors++; $display("FAIL rm_push_count: got %0d want %0d", push_q.size(), N); end
    for (int k = 0; k < N && k < pop_addr_q.size() && k < push_q.size(); k++) begin
      checks++; if (pop_addr_q[k] !== 3'(k)) begin errors++; $display("FAIL rm_pop_addr[%0d]: got %0d want %0d", k, pop_addr_q[k], k); end
      checks++; if (push_q[k] !== expect_px(mask_mem[k], frame_data[k])) begin errors++; $display("FAIL rm_data[%0d]: got %h want %h", k, push_q[k], expect_px(mask_mem[k], frame_data[k])); end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      bit to;
      int loaded;
      clear_logs();
      randomize_frame();
      loaded = 0;
      to = 1'b1;
      mask_ready = 1'b1;
      for (int i = 0; i < 400; i++) begin
        out_full = ($urandom_range(0, 9) < 3);
        if (loaded < N && $urandom_range(0, 1) == 1) begin
          push_word(frame_data[loaded]);
          loaded++;
        end
        tick();
        if (done_cnt > 0) begin
          to = 1'b0;
          break;
        end
      end
      out_full = 1'b0;
      mask_ready = 1'b0;
      tick();
      checks++; if (to !== 1'b0) begin errors++; $display("FAIL rnd%0d_timeout: got timeout want done", f); end
      checks++; if (push_q.size() != N || pop_addr_q.size() != N) begin errors++; $display("FAIL rnd%0d_count: got pushes=%0d pops=%0d want %0d", f, push_q.size(), pop_addr_q.size(), N); end
      for (int k = 0; k < N && k < push_q.size(); k++) begin
        checks++; if (push_q[k] !== expect_px(mask_mem[k], frame_data[k])) begin errors++; $display("FAIL rnd%0d_data[%0d]: got %h want %h", f, k, push_q[k], expect_px(mask_mem[k], frame_data[k])); end
      end
      checks++; if (din_bad != 0) begin errors++; $display("FAIL rnd%0d_idle_din: got %0d want 0", f, din_bad); end
      wr_ptr = rd_ptr;
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_threshold();
    test_mask_ready();
    test_backpressure();
    test_empty_gaps();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
